// File: rtl/sync_fifo_pkg.sv
// Default geometry and flag thresholds shared by the FIFO, its interface and the bench.
package sync_fifo_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_AE_TH    = 2;
    localparam int DEF_AF_TH    = 14;
endpackage

// File: rtl/sync_fifo_if.sv
// Write/read request bundle and status outputs of sync_fifo.
// master: the side that issues requests; slave: the FIFO itself.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [DATA_W-1:0] data_in;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W:0]   data_count;
    logic              empty;
    logic              full;
    logic              almst_empty;
    logic              almst_full;
    logic              err;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, data_count, empty, full, almst_empty, almst_full, err
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, data_count, empty, full, almst_empty, almst_full, err
    );
endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port RAM: synchronous write, registered read (1 cycle), no backpressure.
// Only the read register is reset; the array keeps its contents.
module fifo_mem_dp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_dat
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_dat;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO; read data registered, valid the cycle after an accepted rd_en.
// full blocks writes unless a read frees a slot the same cycle; rejected accesses pulse err.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int ALMST_EMPTY_TH = DEF_AE_TH,
    parameter int ALMST_FULL_TH  = DEF_AF_TH
) (
    input  logic    clk,
    input  logic    n_reset,
    sync_fifo_if.slave bus
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0]   AE_TH_C = (ADDR_W+1)'(ALMST_EMPTY_TH);
    localparam logic [ADDR_W:0]   AF_TH_C = (ADDR_W+1)'(ALMST_FULL_TH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_reject;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_rd_acc = bus.rd_en & ~w_empty;
    // A read at full frees the slot the concurrent write lands in.
    assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);
    assign w_reject = (bus.wr_en & ~w_wr_acc) | (bus.rd_en & ~w_rd_acc);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (bus.data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (bus.data_out)
    );

    assign bus.data_count  = r_count;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almst_empty = (r_count <= AE_TH_C);
    assign bus.almst_full  = (r_count >= AF_TH_C);
    assign bus.err         = r_err;
endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed checks of sync_fifo against a queue-based model.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AE_TH = 2;
    localparam int AF_TH = 14;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sync_fifo #(
        .DATA_W(DW), .ADDR_W(AW), .ALMST_EMPTY_TH(AE_TH), .ALMST_FULL_TH(AF_TH)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] mdl_dout = '0;
    logic          mdl_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mdl_q.size();
        chk({tag, ".count"},  32'(bus.data_count),  32'(n));
        chk({tag, ".empty"},  32'(bus.empty),       32'(n == 0));
        chk({tag, ".full"},   32'(bus.full),        32'(n == DEPTH));
        chk({tag, ".aempty"}, 32'(bus.almst_empty), 32'(n <= AE_TH));
        chk({tag, ".afull"},  32'(bus.almst_full),  32'(n >= AF_TH));
        chk({tag, ".err"},    32'(bus.err),         32'(mdl_err));
        chk({tag, ".dout"},   32'(bus.data_out),    32'(mdl_dout));
    endtask

    // Drive one cycle at the falling edge, advance the model, check at the next falling edge.
    task automatic step(input string tag, input logic wr, input logic rd, input logic [DW-1:0] din);
        bit rd_ok, wr_ok;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = din;
        rd_ok   = rd && (mdl_q.size() > 0);
        wr_ok   = wr && ((mdl_q.size() < DEPTH) || rd_ok);
        mdl_err = (wr && !wr_ok) || (rd && !rd_ok);
        if (rd_ok) mdl_dout = mdl_q.pop_front();
        if (wr_ok) mdl_q.push_back(din);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        n_reset     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        mdl_q.delete();
        mdl_dout = '0;
        mdl_err  = 1'b0;
        check_all("reset");
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        @(negedge clk);
        do_reset();
        step("idle", 1'b0, 1'b0, 8'h00);
        chk("rst_count_const", 32'(bus.data_count), 32'd0);
        chk("rst_empty_const", 32'(bus.empty), 32'd1);
        chk("rst_dout_const",  32'(bus.data_out), 32'd0);

        // Fill to full with 0x11..0x20, then overflow with 0xAA.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(8'h11 + i));
        chk("full_const", 32'(bus.full), 32'd1);
        chk("afull_const", 32'(bus.almst_full), 32'd1);
        step("ovf", 1'b1, 1'b0, 8'hAA);
        chk("ovf_err_const", 32'(bus.err), 32'd1);
        chk("ovf_count_const", 32'(bus.data_count), 32'd16);
        step("ovf_after", 1'b0, 1'b0, 8'h00);
        chk("ovf_err_clear", 32'(bus.err), 32'd0);

        // Drain with single-cycle read pulses.
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 1'b1, 8'h00);
            chk("drain_val", 32'(bus.data_out), 32'(8'h11 + i));
            step("drain_gap", 1'b0, 1'b0, 8'h00);
        end
        chk("drained_empty", 32'(bus.empty), 32'd1);

        // Underflow, then read+write at empty.
        step("udf", 1'b0, 1'b1, 8'h00);
        chk("udf_err_const", 32'(bus.err), 32'd1);
        chk("udf_dout_held", 32'(bus.data_out), 32'h20);
        step("rw_empty", 1'b1, 1'b1, 8'h55);
        chk("rw_empty_err", 32'(bus.err), 32'd1);
        chk("rw_empty_cnt", 32'(bus.data_count), 32'd1);
        step("rd55", 1'b0, 1'b1, 8'h00);
        chk("rd55_val", 32'(bus.data_out), 32'h55);

        // Hold count=5 with concurrent read/write for 20 cycles; pointers wrap.
        for (int i = 0; i < 5; i++) step("pre5", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) step("rw5", 1'b1, 1'b1, 8'($urandom));
        chk("rw5_count", 32'(bus.data_count), 32'd5);

        // Full + simultaneous read/write: both accepted, no err.
        while (mdl_q.size() < DEPTH) step("top", 1'b1, 1'b0, 8'($urandom));
        step("rw_full", 1'b1, 1'b1, 8'hC3);
        chk("rw_full_err", 32'(bus.err), 32'd0);
        chk("rw_full_cnt", 32'(bus.data_count), 32'd16);

        // Mid-operation reset discards contents.
        do_reset();
        for (int i = 0; i < 8; i++) step("pre8", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 3; i++) step("rd8", 1'b0, 1'b1, 8'h00);
        while (mdl_q.size() < 8) step("to8", 1'b1, 1'b0, 8'($urandom));
        do_reset();
        chk("mid_rst_cnt", 32'(bus.data_count), 32'd0);
        chk("mid_rst_dout", 32'(bus.data_out), 32'd0);
        step("w3c", 1'b1, 1'b0, 8'h3C);
        step("r3c", 1'b0, 1'b1, 8'h00);
        chk("r3c_val", 32'(bus.data_out), 32'h3C);

        // Random traffic with shifting read/write bias.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step("rand",
                 1'($urandom_range(0, 9) < (bias == 0 ? 8 : bias == 1 ? 2 : 5)),
                 1'($urandom_range(0, 9) < (bias == 0 ? 2 : bias == 1 ? 8 : 5)),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
